// File: rtl/bsg_tag_serial_rx_pkg.sv
// Shared types for the bit-serial tag receiver: FSM state encoding and header layout.
// Header fields are listed MSB-first so the first wire bit (node LSB) lands in bit 0.
package bsg_tag_serial_rx_pkg;

    localparam int unsigned tag_node_id_width_gp = 4;
    localparam int unsigned tag_len_width_gp     = 5;
    localparam int unsigned tag_max_payload_gp   = 16;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        PARITY,
        DONE
    } state_e;

    typedef struct packed {
        logic                          data_not_reset;
        logic [tag_len_width_gp-1:0]   len;
        logic [tag_node_id_width_gp-1:0] node;
    } tag_hdr_s;

    function automatic int unsigned hdr_width(input int unsigned node_w, input int unsigned len_w);
        return node_w + len_w + 1;
    endfunction

endpackage

// File: rtl/bsg_tag_serial_rx_shifter.sv
// LSB-first serial-in register with a bit counter; bit k of the stream lands in data_o[k].
// done_o flags the shift that completes target_i bits; bits past width_p are counted but not stored.
module bsg_tag_serial_rx_shifter
    import bsg_tag_serial_rx_pkg::*;
#(
    parameter int unsigned width_p     = 8,
    parameter int unsigned cnt_width_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   clear_i,
    input  logic                   shift_i,
    input  logic                   bit_i,
    input  logic [cnt_width_p-1:0] target_i,
    output logic [width_p-1:0]     data_o,
    output logic                   done_o
);

    logic [cnt_width_p-1:0] count;

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            data_o <= '0;
            count  <= '0;
        end else if (shift_i) begin
            for (int unsigned k = 0; k < width_p; k++) begin
                if (32'(count) == k) begin
                    data_o[k] <= bit_i;
                end
            end
            count <= count + cnt_width_p'(1);
        end
    end

    always_comb begin
        done_o = shift_i && (({1'b0, count} + (cnt_width_p + 1)'(1)) == {1'b0, target_i});
    end

endmodule

// File: rtl/bsg_tag_serial_rx.sv
// Deframes the gateway's bit-serial tag stream into {node, len, reset-flag, payload} packets
// held in a single-entry valid/yumi register. Define BSG_TAG_SERIAL_RX_PARITY_EN for an odd-parity trailer.
module bsg_tag_serial_rx
    import bsg_tag_serial_rx_pkg::*;
#(
    parameter int unsigned node_id_width_p = tag_node_id_width_gp,
    parameter int unsigned len_width_p     = tag_len_width_gp,
    parameter int unsigned max_payload_p   = tag_max_payload_gp
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       en_i,
    input  logic                       bit_i,
    output logic                       v_o,
    input  logic                       yumi_i,
    output logic [node_id_width_p-1:0] node_o,
    output logic [len_width_p-1:0]     len_o,
    output logic                       reset_pkt_o,
    output logic [max_payload_p-1:0]   data_o,
    output logic                       overrun_o,
    output logic                       err_o
);

    localparam int unsigned hdr_width_lp     = hdr_width(node_id_width_p, len_width_p);
    localparam int unsigned hdr_cnt_width_lp = $clog2(hdr_width_lp + 1);
    localparam logic [hdr_cnt_width_lp-1:0] hdr_target_lp = hdr_cnt_width_lp'(hdr_width_lp);

    state_e                      state;
    logic                        start, hdr_shift, pay_shift, hdr_last, pay_last;
    logic                        too_long, pkt_bad;
    logic [hdr_width_lp-1:0]     hdr;
    logic [max_payload_p-1:0]    payload;
    logic [node_id_width_p-1:0]  hdr_node;
    logic [len_width_p-1:0]      hdr_len;
    logic                        hdr_dnr;
`ifdef BSG_TAG_SERIAL_RX_PARITY_EN
    logic                        parity;
`endif

    always_comb begin
        start     = (state == IDLE) && en_i && bit_i;
        hdr_shift = (state == HDR) && en_i;
        pay_shift = (state == PAYLOAD) && en_i;
        hdr_node  = hdr[node_id_width_p-1:0];
        hdr_len   = hdr[node_id_width_p +: len_width_p];
        hdr_dnr   = hdr[hdr_width_lp-1];
        too_long  = 32'(hdr_len) > max_payload_p;
    end

    bsg_tag_serial_rx_shifter #(
        .width_p    (hdr_width_lp),
        .cnt_width_p(hdr_cnt_width_lp)
    ) hdr_shifter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (start),
        .shift_i (hdr_shift),
        .bit_i   (bit_i),
        .target_i(hdr_target_lp),
        .data_o  (hdr),
        .done_o  (hdr_last)
    );

    bsg_tag_serial_rx_shifter #(
        .width_p    (max_payload_p),
        .cnt_width_p(len_width_p)
    ) pay_shifter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (start),
        .shift_i (pay_shift),
        .bit_i   (bit_i),
        .target_i(hdr_len),
        .data_o  (payload),
        .done_o  (pay_last)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= IDLE;
            pkt_bad     <= 1'b0;
            v_o         <= 1'b0;
            overrun_o   <= 1'b0;
            err_o       <= 1'b0;
            node_o      <= '0;
            len_o       <= '0;
            reset_pkt_o <= 1'b0;
            data_o      <= '0;
`ifdef BSG_TAG_SERIAL_RX_PARITY_EN
            parity      <= 1'b0;
`endif
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= HDR;
                        pkt_bad <= 1'b0;
`ifdef BSG_TAG_SERIAL_RX_PARITY_EN
                        parity  <= 1'b0;
`endif
                    end
                end
                HDR: begin
                    if (!en_i) begin
                        state <= IDLE;
                        err_o <= 1'b1;
                    end else begin
`ifdef BSG_TAG_SERIAL_RX_PARITY_EN
                        parity <= parity ^ bit_i;
`endif
                        if (hdr_last) begin
                            pkt_bad <= too_long;
                            if (hdr_len != '0) begin
                                state <= PAYLOAD;
                            end else begin
`ifdef BSG_TAG_SERIAL_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= DONE;
`endif
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    if (!en_i) begin
                        state <= IDLE;
                        err_o <= 1'b1;
                    end else begin
`ifdef BSG_TAG_SERIAL_RX_PARITY_EN
                        parity <= parity ^ bit_i;
                        if (pay_last) state <= PARITY;
`else
                        if (pay_last) begin
                            state <= DONE;
                            err_o <= pkt_bad;
                        end
`endif
                    end
                end
`ifdef BSG_TAG_SERIAL_RX_PARITY_EN
                // Running parity plus the trailer bit must be odd; oversize packets also fail here.
                PARITY: begin
                    if (!en_i) begin
                        state <= IDLE;
                        err_o <= 1'b1;
                    end else begin
                        state <= DONE;
                        if (pkt_bad || !(parity ^ bit_i)) begin
                            pkt_bad <= 1'b1;
                            err_o   <= 1'b1;
                        end
                    end
                end
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // A packet finishing in DONE may replace the held one only if it is being consumed now.
            if (state == DONE && !pkt_bad && (!v_o || yumi_i)) begin
                v_o         <= 1'b1;
                node_o      <= hdr_node;
                len_o       <= hdr_len;
                reset_pkt_o <= ~hdr_dnr;
                data_o      <= payload;
            end else if (state == DONE && !pkt_bad) begin
                overrun_o <= 1'b1;
            end else if (yumi_i) begin
                v_o <= 1'b0;
            end
        end
    end

endmodule
